// File: rtl/alu_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_writeback_if
// Purpose  : ALU-result beat handshake between the ALU and writeback stage.
// Revision : 1.0
// ============================================================================
interface alu_writeback_if #(
    parameter int N  = 8,
    parameter int RA = 3
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [2*N-1:0]  in_result;
    logic [RA-1:0]   in_rd;

    modport master (
        output in_valid,
        output in_op,
        output in_result,
        output in_rd,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_op,
        input  in_result,
        input  in_rd,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : alu_writeback
// Purpose  : Registers ALU results into register-file writes; mult is split
//            into a lo/hi register-pair write and zero/carry flags are kept.
// Revision : 1.0
// ============================================================================
module alu_writeback #(
    parameter int N  = 8,
    parameter int RA = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    alu_writeback_if.slave     in_if,
    output logic               rf_we,
    output logic [RA-1:0]      rf_waddr,
    output logic [N-1:0]       rf_wdata,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HI   = 1'b1
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MULT = 3'b101;

    state_t          state_q,   state_d;
    logic            we_q,      we_d;
    logic [RA-1:0]   waddr_q,   waddr_d;
    logic [N-1:0]    wdata_q,   wdata_d;
    logic [RA-1:0]   hi_addr_q, hi_addr_d;
    logic [N-1:0]    hi_data_q, hi_data_d;
    logic            zero_q,    zero_d;
    logic            carry_q,   carry_d;

    logic            w_accept;
    logic            w_is_mult;

    // Ready depends on state only, so the producer never sees a loop.
    assign in_if.in_ready = (state_q == S_IDLE);
    assign w_accept       = in_if.in_valid && (state_q == S_IDLE);
    assign w_is_mult      = (in_if.in_op == OP_MULT);

    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        hi_addr_d = hi_addr_q;
        hi_data_d = hi_data_q;
        zero_d    = zero_q;
        carry_d   = carry_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    we_d    = 1'b1;
                    waddr_d = in_if.in_rd;
                    wdata_d = in_if.in_result[N-1:0];
                    if (w_is_mult) begin
                        state_d   = S_HI;
                        hi_addr_d = in_if.in_rd + RA'(1);
                        hi_data_d = in_if.in_result[2*N-1:N];
                        zero_d    = (in_if.in_result == '0);
                    end else begin
                        zero_d    = (in_if.in_result[N-1:0] == '0);
                    end
                    case (in_if.in_op)
                        OP_ADD, OP_SUB: carry_d = in_if.in_result[N];
                        OP_MULT:        carry_d = |in_if.in_result[2*N-1:N];
                        default:        carry_d = 1'b0;
                    endcase
                end
            end
            S_HI: begin
                we_d    = 1'b1;
                waddr_d = hi_addr_q;
                wdata_d = hi_data_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            hi_addr_q <= '0;
            hi_data_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            hi_addr_q <= hi_addr_d;
            hi_data_q <= hi_data_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
        end
    end

    assign rf_we      = we_q;
    assign rf_waddr   = waddr_q;
    assign rf_wdata   = wdata_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;
    assign busy       = (state_q == S_HI);

endmodule
`default_nettype wire
